bingo_board_map: RTL and testbench

- Holds the 5x25-bit Bingo board map that feeds the per-cell display window stage.
- Shuffles the numbers 1..25 into a random permutation on request.
- Clears a cell to 0 when its number is called (0 = marked; the display draws background).
- Counts completed lines and flags bingo.

---
 rtl/bingo_board_map.sv | 133 +++++++++++++
 tb/tb_bingo_board_map.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bingo_board_map.sv
// 5x5 Bingo board: shuffles 1..25 with an LFSR-driven Fisher-Yates pass,
// marks called numbers, counts completed lines and flags bingo.
module bingo_board_map #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          WIN_LINES = 5
) (
    input  logic         clk_25MHz,
    input  logic         all_rst,
    input  logic         shuffle_start,
    input  logic         call_valid,
    input  logic [4:0]   call_num,
    output logic [124:0] map,
    output logic         busy,
    output logic         ready,
    output logic         call_done,
    output logic         call_hit,
    output logic [3:0]   lines,
    output logic         bingo
);

    typedef enum logic [1:0] {ST_PLAY, ST_INIT, ST_SHUFFLE} state_t;

    localparam logic [15:0] LFSR_RST = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  WIN_L    = 4'(WIN_LINES);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [4:0]       k_q, k_d;
    logic [24:0][4:0] map_q, map_d;
    logic             call_done_q, call_done_d;
    logic             call_hit_q, call_hit_d;
    logic [3:0]       lines_q, lines_d;
    logic             bingo_q, bingo_d;
    logic [12:0]      prod;
    logic [4:0]       j;
    logic             in_play;

    function automatic logic [24:0][4:0] identity_map();
        logic [24:0][4:0] m;
        for (int i = 0; i < 25; i++) m[i] = 5'(i + 1);
        return m;
    endfunction

    function automatic logic [3:0] count_lines(input logic [24:0][4:0] m);
        logic [24:0] z;
        logic [3:0]  n;
        logic        d0, d1;
        for (int i = 0; i < 25; i++) z[i] = (m[i] == 5'd0);
        n = 4'd0;
        for (int r = 0; r < 5; r++) begin
            n = n + {3'b000, &z[5*r +: 5]};
            n = n + {3'b000, z[r] & z[r+5] & z[r+10] & z[r+15] & z[r+20]};
        end
        d0 = z[0] & z[6] & z[12] & z[18] & z[24];
        d1 = z[4] & z[8] & z[12] & z[16] & z[20];
        n = n + {3'b000, d0} + {3'b000, d1};
        return n;
    endfunction

    assign in_play = (state_q == ST_PLAY);
    // j = floor(r * (k+1) / 256) stays within 0..k for any 8-bit r
    assign prod = 13'(lfsr_q[7:0]) * 13'(k_q + 5'd1);
    assign j    = prod[12:8];

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        map_d       = map_q;
        call_done_d = 1'b0;
        call_hit_d  = 1'b0;
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        case (state_q)
            ST_PLAY: begin
                if (shuffle_start) begin
                    state_d = ST_INIT;
                end else if (call_valid && !bingo_q) begin
                    call_done_d = 1'b1;
                    for (int i = 0; i < 25; i++) begin
                        if (call_num != 5'd0 && map_q[i] == call_num) begin
                            map_d[i]   = 5'd0;
                            call_hit_d = 1'b1;
                        end
                    end
                end
            end
            ST_INIT: begin
                map_d   = identity_map();
                k_d     = 5'd24;
                state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                map_d[k_q] = map_q[j];
                map_d[j]   = map_q[k_q];
                k_d        = k_q - 5'd1;
                if (k_q == 5'd1) state_d = ST_PLAY;
            end
            default: state_d = ST_PLAY;
        endcase
        lines_d = (in_play && !shuffle_start) ? count_lines(map_q) : 4'd0;
        bingo_d = (in_play && shuffle_start) ? 1'b0 : (bingo_q | (lines_d >= WIN_L));
    end

    always_ff @(posedge clk_25MHz or negedge all_rst) begin
        if (!all_rst) begin
            state_q     <= ST_PLAY;
            lfsr_q      <= LFSR_RST;
            k_q         <= 5'd0;
            map_q       <= identity_map();
            call_done_q <= 1'b0;
            call_hit_q  <= 1'b0;
            lines_q     <= 4'd0;
            bingo_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            k_q         <= k_d;
            map_q       <= map_d;
            call_done_q <= call_done_d;
            call_hit_q  <= call_hit_d;
            lines_q     <= lines_d;
            bingo_q     <= bingo_d;
        end
    end

    assign map       = map_q;
    assign busy      = !in_play;
    assign ready     = in_play;
    assign call_done = call_done_q;
    assign call_hit  = call_hit_q;
    assign lines     = lines_q;
    assign bingo     = bingo_q;

endmodule

// File: tb/tb_bingo_board_map.sv
// Directed bench for bingo_board_map: reset, calls, bingo, shuffle, mid-shuffle reset.
module tb_bingo_board_map;

    logic         clk_25MHz = 1'b0;
    logic         all_rst = 1'b0;
    logic         shuffle_start = 1'b0;
    logic         call_valid = 1'b0;
    logic [4:0]   call_num = 5'd0;
    logic [124:0] map;
    logic         busy, ready, call_done, call_hit, bingo;
    logic [3:0]   lines;

    int cmp = 0;
    int err = 0;

    bingo_board_map #(.SEED(16'hACE1), .WIN_LINES(5)) dut (
        .clk_25MHz     (clk_25MHz),
        .all_rst       (all_rst),
        .shuffle_start (shuffle_start),
        .call_valid    (call_valid),
        .call_num      (call_num),
        .map           (map),
        .busy          (busy),
        .ready         (ready),
        .call_done     (call_done),
        .call_hit      (call_hit),
        .lines         (lines),
        .bingo         (bingo)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    function automatic logic [4:0] cell_of(input logic [124:0] m, input int i);
        return m[5*i +: 5];
    endfunction

    function automatic logic [124:0] ident();
        logic [124:0] m;
        for (int i = 0; i < 25; i++) m[5*i +: 5] = 5'(i + 1);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic do_reset();
        all_rst = 1'b0;
        shuffle_start = 1'b0;
        call_valid = 1'b0;
        call_num = 5'd0;
        tick();
        tick();
        all_rst = 1'b1;
    endtask

    task automatic call(input logic [4:0] n);
        call_valid = 1'b1;
        call_num = n;
        tick();
        call_valid = 1'b0;
    endtask

    // Starts a shuffle (optionally re-pulsing shuffle_start mid-way) and returns busy cycles.
    task automatic run_shuffle(input int repulse_at, output int n);
        shuffle_start = 1'b1;
        tick();
        shuffle_start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            shuffle_start = (n == repulse_at);
            tick();
        end
        shuffle_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cmp++; if (ready !== 1'b1) begin err++; $display("FAIL reset_ready got %0b want 1", ready); end
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %0b want 0", busy); end
        cmp++; if (lines !== 4'd0) begin err++; $display("FAIL reset_lines got %0d want 0", lines); end
        cmp++; if (bingo !== 1'b0) begin err++; $display("FAIL reset_bingo got %0b want 0", bingo); end
        cmp++; if (call_done !== 1'b0) begin err++; $display("FAIL reset_call_done got %0b want 0", call_done); end
        cmp++; if (cell_of(map, 0) !== 5'd1) begin err++; $display("FAIL reset_cell0 got %0d want 1", cell_of(map, 0)); end
        cmp++; if (cell_of(map, 24) !== 5'd25) begin err++; $display("FAIL reset_cell24 got %0d want 25", cell_of(map, 24)); end
        cmp++; if (map !== ident()) begin err++; $display("FAIL reset_map got %h want %h", map, ident()); end
    endtask

    task automatic test_row_calls();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            call(5'(v));
            cmp++; if (call_done !== 1'b1 || call_hit !== 1'b1) begin
                err++; $display("FAIL row_call_%0d done=%0b hit=%0b want 1/1", v, call_done, call_hit);
            end
            cmp++; if (cell_of(map, v - 1) !== 5'd0) begin
                err++; $display("FAIL row_cell_%0d got %0d want 0", v - 1, cell_of(map, v - 1));
            end
        end
        tick();
        cmp++; if (lines !== 4'd1) begin err++; $display("FAIL row_lines got %0d want 1", lines); end
        cmp++; if (bingo !== 1'b0) begin err++; $display("FAIL row_bingo got %0b want 0", bingo); end
        cmp++; if (call_done !== 1'b0) begin err++; $display("FAIL row_done_pulse got %0b want 0", call_done); end
    endtask

    task automatic test_miss();
        logic [124:0] snap;
        call(5'd7);
        cmp++; if (call_done !== 1'b1 || call_hit !== 1'b1) begin
            err++; $display("FAIL miss_first7 done=%0b hit=%0b want 1/1", call_done, call_hit);
        end
        cmp++; if (cell_of(map, 6) !== 5'd0) begin err++; $display("FAIL miss_cell6 got %0d want 0", cell_of(map, 6)); end
        snap = map;
        call(5'd7);
        cmp++; if (call_done !== 1'b1 || call_hit !== 1'b0) begin
            err++; $display("FAIL miss_second7 done=%0b hit=%0b want 1/0", call_done, call_hit);
        end
        call(5'd0);
        cmp++; if (call_done !== 1'b1 || call_hit !== 1'b0) begin
            err++; $display("FAIL miss_call0 done=%0b hit=%0b want 1/0", call_done, call_hit);
        end
        call(5'd30);
        cmp++; if (call_done !== 1'b1 || call_hit !== 1'b0) begin
            err++; $display("FAIL miss_call30 done=%0b hit=%0b want 1/0", call_done, call_hit);
        end
        cmp++; if (map !== snap) begin err++; $display("FAIL miss_map got %h want %h", map, snap); end
    endtask

    task automatic test_bingo();
        do_reset();
        for (int v = 1; v <= 20; v++) call(5'(v));
        tick();
        cmp++; if (lines !== 4'd4) begin err++; $display("FAIL bingo_lines4 got %0d want 4", lines); end
        cmp++; if (bingo !== 1'b0) begin err++; $display("FAIL bingo_early got %0b want 0", bingo); end
        call(5'd21);
        tick();
        // cell 20 completes column 0 and the anti-diagonal 4,8,12,16,20 together
        cmp++; if (lines !== 4'd6) begin err++; $display("FAIL bingo_lines got %0d want 6", lines); end
        cmp++; if (bingo !== 1'b1) begin err++; $display("FAIL bingo_flag got %0b want 1", bingo); end
        call(5'd22);
        cmp++; if (call_done !== 1'b0) begin err++; $display("FAIL bingo_call_ignored done=%0b want 0", call_done); end
        cmp++; if (cell_of(map, 21) !== 5'd22) begin err++; $display("FAIL bingo_cell21 got %0d want 22", cell_of(map, 21)); end
        tick();
        cmp++; if (bingo !== 1'b1) begin err++; $display("FAIL bingo_sticky got %0b want 1", bingo); end
    endtask

    task automatic test_shuffle();
        int n;
        logic [24:0] seen;
        logic ok;
        logic [4:0] v;
        shuffle_start = 1'b1;
        tick();
        shuffle_start = 1'b0;
        cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin
            err++; $display("FAIL shuf_start busy=%0b ready=%0b want 1/0", busy, ready);
        end
        cmp++; if (lines !== 4'd0 || bingo !== 1'b0) begin
            err++; $display("FAIL shuf_clear lines=%0d bingo=%0b want 0/0", lines, bingo);
        end
        n = 1;
        while (busy && n < 40) begin
            // a second request while busy must not extend the shuffle
            shuffle_start = (n == 5);
            call_valid = (n == 7);
            call_num = 5'd3;
            tick();
            if (busy) n++;
            cmp++; if (call_done !== 1'b0) begin err++; $display("FAIL shuf_call_busy done=%0b want 0", call_done); end
        end
        shuffle_start = 1'b0;
        call_valid = 1'b0;
        cmp++; if (n !== 25) begin err++; $display("FAIL shuf_busy_cycles got %0d want 25", n); end
        cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin
            err++; $display("FAIL shuf_ready busy=%0b ready=%0b want 0/1", busy, ready);
        end
        tick();
        seen = '0;
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            v = cell_of(map, i);
            if (v == 5'd0 || v > 5'd25 || seen[v - 5'd1]) ok = 1'b0;
            else seen[v - 5'd1] = 1'b1;
        end
        cmp++; if (!(ok && seen == 25'h1FFFFFF)) begin err++; $display("FAIL shuf_perm map=%h", map); end
        cmp++; if (map === ident()) begin err++; $display("FAIL shuf_changed map=%h still identity", map); end
        cmp++; if (lines !== 4'd0 || bingo !== 1'b0) begin
            err++; $display("FAIL shuf_after lines=%0d bingo=%0b want 0/0", lines, bingo);
        end
    endtask

    task automatic test_start_with_call();
        int n;
        shuffle_start = 1'b1;
        call_valid = 1'b1;
        call_num = cell_of(map, 0);
        tick();
        shuffle_start = 1'b0;
        call_valid = 1'b0;
        cmp++; if (call_done !== 1'b0 || busy !== 1'b1) begin
            err++; $display("FAIL start_call done=%0b busy=%0b want 0/1", call_done, busy);
        end
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL start_call_timeout busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid_shuffle();
        int n;
        logic [124:0] perm_a;
        do_reset();
        repeat (3) tick();
        run_shuffle(-1, n);
        perm_a = map;
        do_reset();
        repeat (3) tick();
        shuffle_start = 1'b1;
        tick();
        shuffle_start = 1'b0;
        repeat (9) tick();
        cmp++; if (busy !== 1'b1) begin err++; $display("FAIL mid_busy got %0b want 1", busy); end
        all_rst = 1'b0;
        #1;
        cmp++; if (map !== ident()) begin err++; $display("FAIL mid_map got %h want %h", map, ident()); end
        cmp++; if (busy !== 1'b0 || ready !== 1'b1) begin
            err++; $display("FAIL mid_state busy=%0b ready=%0b want 0/1", busy, ready);
        end
        do_reset();
        repeat (3) tick();
        run_shuffle(-1, n);
        cmp++; if (n !== 25) begin err++; $display("FAIL repro_cycles got %0d want 25", n); end
        cmp++; if (map !== perm_a) begin err++; $display("FAIL repro_perm got %h want %h", map, perm_a); end
    endtask

    initial begin
        test_reset();
        test_row_calls();
        test_miss();
        test_bingo();
        test_shuffle();
        test_start_with_call();
        test_reset_mid_shuffle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
